// File: rtl/onehot_encoder_fifo.sv
// onehot_encoder_fifo
//   Accepts a 16-line one-hot vector from the decoder. Legal vectors are
//   encoded back to their index and buffered in a small first-word-fall-through
//   FIFO. Illegal vectors are consumed, dropped, and raise a sticky Err flag.
//
//   Optional build macro ONEHOT_PRIORITY_EN: multi-hot vectors become legal and
//   encode to their lowest set index; only an all-zero vector is illegal.
//   Without the macro, exactly one set bit is required.
module onehot_encoder_fifo #(
  parameter int LINES  = 16,
  parameter int CODE_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [0:LINES-1]         X,
  input  logic                     X_Valid,
  output logic                     X_Ready,
  output logic [CODE_W-1:0]        Code,
  output logic                     Code_Valid,
  input  logic                     Code_Ready,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];

  logic [LINES-1:0]  x_vec;
  logic [CODE_W-1:0] enc;
  logic              any_set;
  logic              multi_set;
  logic              legal;
  logic              accept;
  logic              push;
  logic              pop;

  // Classify the input vector and find its lowest set index.
  always_comb begin
    x_vec = '0;
    enc   = '0;
    for (int i = 0; i < LINES; i++) begin
      x_vec[i] = X[i];
    end
    for (int i = LINES - 1; i >= 0; i--) begin
      if (x_vec[i]) enc = CODE_W'(i);
    end
    any_set   = |x_vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_set = |(x_vec & (x_vec - LINES'(1)));
`ifdef ONEHOT_PRIORITY_EN
    legal = any_set;
`else
    legal = any_set & ~multi_set;
`endif
  end

  // Handshakes and outputs; all outputs derive from registered state only.
  always_comb begin
    X_Ready    = (count_q != CNT_W'(DEPTH));
    Code_Valid = (count_q != '0);
    Code       = Code_Valid ? mem_q[rd_ptr_q] : '0;
    Count      = count_q;
    Err        = err_q;
    accept     = X_Valid & X_Ready;
    push       = accept & legal;
    pop        = Code_Valid & Code_Ready;
  end

  // Next-state for pointers, occupancy, error flag and storage.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = enc;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (accept && !legal) begin
      err_d = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage has no reset; entries are only visible once counted as valid.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_onehot_encoder_fifo.sv
// Testbench for onehot_encoder_fifo: directed steps followed by randomized
// traffic, all compared against a queue-based reference model.
module tb_onehot_encoder_fifo;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [0:15] X;
  logic        X_Valid;
  logic        X_Ready;
  logic [3:0]  Code;
  logic        Code_Valid;
  logic        Code_Ready;
  logic [2:0]  Count;
  logic        Err;

  int n_cmp = 0;
  int n_bad = 0;

  int q[$];
  bit m_err;

  onehot_encoder_fifo dut (
    .Clk(Clk), .Rst(Rst), .X(X), .X_Valid(X_Valid), .X_Ready(X_Ready),
    .Code(Code), .Code_Valid(Code_Valid), .Code_Ready(Code_Ready),
    .Count(Count), .Err(Err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [0:15] oh(int k);
    logic [0:15] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic int low_idx(logic [0:15] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit is_legal(logic [0:15] v);
`ifdef ONEHOT_PRIORITY_EN
    return $countones(v) >= 1;
`else
    return $countones(v) == 1;
`endif
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    check("count",      32'(Count),      32'(n));
    check("code_valid", 32'(Code_Valid), 32'(n != 0));
    check("x_ready",    32'(X_Ready),    32'(n != DEPTH));
    check("err",        32'(Err),        32'(m_err));
    check("code",       32'(Code),       (n != 0) ? 32'(q[0]) : 32'd0);
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(bit rst, bit xv, logic [0:15] x, bit cr);
    bit acc;
    bit pp;
    Rst        = rst;
    X_Valid    = xv;
    X          = x;
    Code_Ready = cr;
    if (rst) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      acc = xv && (q.size() < DEPTH);
      pp  = cr && (q.size() != 0);
      if (pp) void'(q.pop_front());
      if (acc) begin
        if (is_legal(x)) q.push_back(low_idx(x));
        else m_err = 1'b1;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    check_outputs();
  endtask

  initial begin
    logic [0:15] xr;
    int          r;
    Rst = 1'b1; X = '0; X_Valid = 1'b0; Code_Ready = 1'b0;
    m_err = 1'b0;
    @(negedge Clk);

    // 1: reset for two cycles, then idle
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    step(0, 0, '0, 0);

    // 2: single push of code 5, then it drains
    step(0, 1, oh(5), 1);
    step(0, 0, '0, 1);

    // 3: fill to full, rejected fifth push, then drain in order
    step(0, 1, oh(1), 0);
    step(0, 1, oh(2), 0);
    step(0, 1, oh(3), 0);
    step(0, 1, oh(4), 0);
    step(0, 1, oh(9), 0);
    step(0, 1, oh(9), 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // 4: all-zero and multi-hot vectors
    step(1, 0, '0, 0);
    step(0, 1, '0, 0);
    xr = oh(3) | oh(7);
    step(0, 1, xr, 0);
    step(0, 0, '0, 1);

    // 5: simultaneous push and pop at Count=2, then mid-stream reset
    step(1, 0, '0, 0);
    step(0, 1, oh(10), 0);
    step(0, 1, oh(11), 0);
    step(0, 1, oh(15), 1);
    step(0, 0, '0, 1);
    step(0, 1, oh(6), 0);
    step(1, 1, oh(8), 1);
    step(0, 0, '0, 0);

    // 6: interleaved pushes and pops across pointer wrap
    for (int i = 0; i < 10; i++) step(0, 1, oh(i), 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) xr = oh($urandom_range(0, 15));
      else if (r < 70) xr = '0;
      else xr = 16'($urandom);
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 7), xr,
           ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_fifo.md
Name: onehot_encoder_fifo

Overview:
Downstream consumer of the 4-to-16 decoder. Takes the 16-line one-hot vector on a valid/ready handshake and checks that it is legal one-hot. Legal vectors are encoded back to a 4-bit code and buffered in a small first-word-fall-through FIFO. The output side presents codes to the next stage on a second valid/ready handshake. Illegal vectors are dropped and flagged.

Parameters:
LINES, 16, number of input lines; fixed at 16 for this revision.
CODE_W, 4, output code width, equal to log2(LINES).
DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
Clk  input  1  rising-edge clock, single clock domain
Rst  input  1  synchronous, active-high reset
X  input  [0:15]  vector from the decoder; X[i] high means code i
X_Valid  input  1  X is presented this cycle
X_Ready  output  1  block can accept X this cycle
Code  output  4  encoded index at the FIFO head
Code_Valid  output  1  Code is valid (FIFO not empty)
Code_Ready  input  1  downstream consumes Code this cycle
Count  output  3  FIFO occupancy, 0..DEPTH (width log2(DEPTH)+1)
Err  output  1  sticky flag for an illegal input pattern

Behaviour:
- Reset: Rst sampled on the Clk rising edge.
  - Clears read pointer, write pointer and Count to 0, and Err to 0.
  - Outputs after reset: Code_Valid=0, X_Ready=1, Count=0, Err=0, Code=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all buffered entries, and any handshake in that cycle is ignored.
- Input acceptance: accept = X_Valid & X_Ready.
  - X_Ready = (Count != DEPTH). It is combinational from registered state only and never depends on X_Valid.
- Legality: legal iff exactly one bit of X is set.
  - Accepted legal vector: its index i (0..15) is written at the write pointer on that edge, and the write pointer increments.
  - Accepted illegal vector (zero bits or two or more bits set): nothing is written, and Err is set to 1 on that edge. Err stays 1 until Rst.
  - An illegal vector still completes the handshake (it is consumed), so the upstream never stalls on bad data.
- Output: Code_Valid = (Count != 0), and Code = entry at the read pointer (first-word fall-through).
  - pop = Code_Valid & Code_Ready advances the read pointer.
  - Latency: a legal vector accepted at edge N appears on Code/Code_Valid after edge N (visible in cycle N+1), provided it is at the head.
- Count updates:
  - +1 on a legal push with no pop.
  - -1 on a pop with no push.
  - Unchanged when both occur, or when neither occurs.
  - An illegal accept does not change Count.
- Boundaries:
  - Full (Count=DEPTH): X_Ready=0, so there is no push even if a pop occurs the same cycle. X_Ready rises in the cycle after the pop.
  - Empty: Code_Valid=0. Code_Ready is ignored, and there is no underflow.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Simultaneous push and pop at 0<Count<DEPTH: both take effect.
- Code holds stable while Code_Valid=1 and Code_Ready=0.

Optional Feature:
Macro ONEHOT_PRIORITY_EN.
- Defined: a multi-hot vector is legal. It encodes to the lowest set index and is pushed. Only an all-zero vector sets Err and is dropped.
- Undefined: strict one-hot checking as in Behaviour. Multi-hot vectors are dropped and set Err.

Test Plan:
1. Rst=1 for 2 cycles, then release -> Code_Valid=0, X_Ready=1, Count=0, Err=0.
2. Push X with only bit 5 set (X[5]=1), with Code_Ready=1 -> next cycle Code=4'd5, Code_Valid=1; it pops, and Count returns to 0.
3. Code_Ready=0; push X[1], X[2], X[3], X[4] on consecutive cycles -> Count=4, X_Ready=0. A fifth push with X[9] is not accepted. Then Code_Ready=1 -> codes 1,2,3,4 in order, and X_Ready=1 one cycle after the first pop.
4. Push X=0 then X with bits 3 and 7 set -> Err=1, Count stays 0. With ONEHOT_PRIORITY_EN defined: X=0 sets Err, and the bits-3/7 vector pushes Code=4'd3.
5. At Count=2 with X_Valid=1 (X[15]) and Code_Ready=1 in the same cycle -> Count stays 2, and 4'd15 is delivered after the older entries. Then Rst=1 mid-stream -> Count=0, Code_Valid=0, Err=0 next cycle.
6. Wrap: 10 legal pushes and pops interleaved, codes 0..9 -> output order 0..9, no loss.
